// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the iterative HI/LO multiply/divide sequencer.
// Optional unsigned support is enabled by defining MULT_DIV_UNSIGNED_EN.
package mult_div_pkg;

  localparam int unsigned MD_WIDTH = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned MD_CNT_W = cnt_width(MD_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_DONE = 3'd3,
    ST_DIVZ = 3'd4
  } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration on unsigned magnitudes: shift in a dividend
// bit, subtract the divisor if it fits, and emit the quotient bit.
module div_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_c_o,
  output logic             q_bit_c_o
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted   = {rem_i, dvd_bit_i};
    q_bit_c_o = (shifted >= {1'b0, dvs_i});
    // Remainder stays below the divisor, so the difference fits in WIDTH bits.
    rem_c_o   = q_bit_c_o ? (shifted[WIDTH-1:0] - dvs_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed Booth multiply / restoring divide feeding the HI/LO registers.
// Define MULT_DIV_UNSIGNED_EN to add the op_unsigned port (multu/divu).
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             write_hi,
  output logic             write_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q, corr_q;
  logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
  logic             qneg_q, rneg_q;
  logic             busy_q, done_q, wr_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             uns_c, last_c, a_neg_c, b_neg_c, qbit_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, rem_n_c, quo_n_c, q_n_c;
  logic [WIDTH:0]   m_c, booth_sum_c, acc_n_c;

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns_c = op_unsigned;
`else
  assign uns_c = 1'b0;
`endif

  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

  // Operand conditioning at the accepting edge.
  always_comb begin
    a_neg_c = ~uns_c & op_a[WIDTH-1];
    b_neg_c = ~uns_c & op_b[WIDTH-1];
    a_mag_c = a_neg_c ? WIDTH'(-op_a) : op_a;
    b_mag_c = b_neg_c ? WIDTH'(-op_b) : op_b;
    m_c     = {a_neg_c, op_a};
  end

  // Radix-2 Booth step on {acc, Q, q-1}, WIDTH+1-bit accumulator.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum_c = acc_q + m_q;
      2'b10:   booth_sum_c = acc_q - m_q;
      default: booth_sum_c = acc_q;
    endcase
    acc_n_c = {booth_sum_c[WIDTH], booth_sum_c[WIDTH:1]};
    q_n_c   = {booth_sum_c[0], q_q[WIDTH-1:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_c_o   (rem_n_c),
    .q_bit_c_o (qbit_c)
  );

  assign quo_n_c = {dvd_q[WIDTH-2:0], qbit_c};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      corr_q  <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Multiply has priority; a simultaneous divide request is dropped.
          if (start_mult) begin
            state_q <= ST_MULT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= m_c;
            q_q     <= op_b;
            qm1_q   <= 1'b0;
            corr_q  <= uns_c & op_b[WIDTH-1];
          end else if (start_div) begin
            busy_q <= 1'b1;
            if (op_b == '0) begin
              state_q <= ST_DIVZ;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= ST_DIV;
              cnt_q   <= '0;
              rem_q   <= '0;
              dvd_q   <= a_mag_c;
              dvs_q   <= b_mag_c;
              qneg_q  <= a_neg_c ^ b_neg_c;
              rneg_q  <= a_neg_c;
            end
          end
        end
        ST_MULT: begin
          acc_q <= acc_n_c;
          q_q   <= q_n_c;
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            wr_q    <= 1'b1;
            // Booth treats Q as signed; an unsigned multiplier with MSB set needs +M<<WIDTH.
            hi_q    <= acc_n_c[WIDTH-1:0] + (corr_q ? m_q[WIDTH-1:0] : '0);
            lo_q    <= q_n_c;
          end
        end
        ST_DIV: begin
          rem_q <= rem_n_c;
          dvd_q <= quo_n_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            wr_q    <= 1'b1;
            hi_q    <= rneg_q ? WIDTH'(-rem_n_c) : rem_n_c;
            lo_q    <= qneg_q ? WIDTH'(-quo_n_c) : quo_n_c;
          end
        end
        ST_DONE, ST_DIVZ: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign write_hi = wr_q;
  assign write_lo = wr_q;
  assign div_zero = dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: expected HI/LO results are queued at issue
// and compared when done pulses; also covers latency, arbitration and reset.
module tb_mult_div_ctrl;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start_mult = 1'b0;
  logic         start_div = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
`ifdef MULT_DIV_UNSIGNED_EN
  logic         op_unsigned = 1'b0;
`endif
  logic         busy, done, write_hi, write_lo, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         sb_q[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  always #5 clock = ~clock;

  mult_div_ctrl #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef MULT_DIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .busy       (busy),
    .done       (done),
    .write_hi   (write_hi),
    .write_lo   (write_lo),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .div_zero   (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t model(input bit is_mult, input bit uns,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sd, q, r;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    if (is_mult) begin
      p    = uns ? ({32'b0, a} * {32'b0, b}) : ({{32{a[31]}}, a} * {{32{b[31]}}, b});
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi = last_hi;
      e.lo = last_lo;
      e.dz = 1'b1;
    end else if (uns) begin
      e.lo = a / b;
      e.hi = a % b;
    end else begin
      sa   = longint'(int'(a));
      sd   = longint'(int'(b));
      q    = sa / sd;
      r    = sa % sd;
      e.lo = 32'(q);
      e.hi = 32'(r);
    end
    return e;
  endfunction

  // Issue one request, then wait (bounded) for done and score the result.
  task automatic do_op(input bit sm, input bit sd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit uns, input int inject_at, input string tag);
    exp_t e;
    int   k, busy_bad, lat, extra;
    e   = model(sm, uns, a, b);
    lat = (!sm && b == '0) ? 1 : W + 1;
    sb_q.push_back(e);
    start_mult = sm;
    start_div  = sd;
    op_a       = a;
    op_b       = b;
`ifdef MULT_DIV_UNSIGNED_EN
    op_unsigned = uns;
`endif
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    k          = 1;
    busy_bad   = 0;
    while (done !== 1'b1 && k < 200) begin
      if (busy !== 1'b1) busy_bad++;
      if (k == inject_at) begin
        start_div = 1'b1;
        op_b      = '0;
      end
      tick();
      start_div = 1'b0;
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    e = sb_q.pop_front();
    check({tag, " hi_out"}, 64'(hi_out), 64'(e.hi));
    check({tag, " lo_out"}, 64'(lo_out), 64'(e.lo));
    check({tag, " strobes"}, {62'd0, write_hi, write_lo}, {62'd0, !e.dz, !e.dz});
    check({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
    check({tag, " busy_at_done"}, 64'(busy), 64'd1);
    if (!e.dz) begin
      last_hi = e.hi;
      last_lo = e.lo;
    end
    tick();
    check({tag, " after_done"}, {59'd0, busy, done, write_hi, write_lo, div_zero}, 64'd0);
    if (inject_at > 0) begin
      extra = 0;
      repeat (40) begin
        if (done === 1'b1) extra++;
        tick();
      end
      check({tag, " extra_done"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rm;

    repeat (2) @(posedge clock);
    #1;
    check("reset ctrl", {60'd0, busy, done, write_hi, write_lo}, 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset hi/lo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;
    tick();

    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0, "mult 7*-3");
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, "div -7/2");
    do_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 0, "div 100/7");
    do_op(1'b1, 1'b0, 32'h48D1_59E0, 32'h4000_0000, 1'b0, 0, "mult hi=12345678");
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 0, "divz");
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, "mult min*min");
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div min/-1");
    do_op(1'b1, 1'b1, 32'h0000_1234, 32'd0, 1'b0, 0, "both starts");
    do_op(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 10, "mult inject div");

    // Asynchronous reset in cycle 10 of a divide.
    start_div = 1'b1;
    op_a      = 32'd1000;
    op_b      = 32'd3;
    tick();
    start_div = 1'b0;
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    check("async reset ctrl", {61'd0, busy, done, div_zero}, 64'd0);
    check("async reset hi/lo", {hi_out, lo_out}, 64'd0);
    last_hi = '0;
    last_lo = '0;
    @(posedge clock);
    #2 reset = 1'b0;
    tick();
    check("post reset idle", {59'd0, busy, done, write_hi, write_lo, div_zero}, 64'd0);
    do_op(1'b1, 1'b0, 32'd6, 32'd7, 1'b0, 0, "mult 6*7");

    for (int i = 0; i < 8; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op(rm, !rm, ra, rb, 1'b0, 0, $sformatf("rand%0d", i));
    end

`ifdef MULT_DIV_UNSIGNED_EN
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "multu max");
    do_op(1'b1, 1'b0, 32'h8000_0001, 32'd3, 1'b1, 0, "multu a-msb");
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, "divu big/2");
    do_op(1'b0, 1'b1, 32'h1234_5678, 32'h8000_0000, 1'b1, 0, "divu small/big");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Iterative signed multiply/divide sequencer for the multicycle CPU's HI/LO resource. The main control FSM issues a one-cycle start. This block runs a WIDTH-iteration Booth multiply or restoring divide, then presents results plus HI/LO write strobes for the HI and LO registers. It flags divide-by-zero to the exception logic and holds busy so control can stall.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_mult  in  1  one-cycle request, signed multiply (mult)
start_div  in  1  one-cycle request, signed divide (div)
op_a  in  WIDTH  multiplicand / dividend (register A value)
op_b  in  WIDTH  multiplier / divisor (register B value)
busy  out  1  high from start acceptance through the DONE/DIVZ cycle
done  out  1  one-cycle pulse, operation finished
write_hi  out  1  one-cycle strobe, HI register captures hi_out
write_lo  out  1  one-cycle strobe, LO register captures lo_out
hi_out  out  WIDTH  mult: product[2W-1:W]; div: remainder
lo_out  out  WIDTH  mult: product[W-1:0]; div: quotient
div_zero  out  1  one-cycle pulse, divisor was zero

Behaviour:
- Clocking: single clock domain. Reset is asynchronous and active-high. All outputs are registered.
- Reset (any time, including mid-operation): state=IDLE, iteration counter=0, working registers=0, all outputs 0.
- States: IDLE, MULT, DIV, DONE, DIVZ.
- IDLE transitions:
  - start_mult=1 → MULT.
  - start_div=1 and op_b≠0 → DIV.
  - start_div=1 and op_b=0 → DIVZ.
  - Both starts high: mult wins; start_div is dropped.
- Operand capture: operands are latched at the accepting edge (E0). op_a and op_b may change afterwards.
- Starts outside IDLE: ignored, not queued.
- MULT: radix-2 Booth on {A=0, Q=op_b, q-1=0}, M=op_a.
  - One iteration per edge, E1..E{WIDTH}.
  - Each iteration: add/subtract M per {Q[0], q-1}, then arithmetic right shift of {A,Q,q-1}.
  - Arithmetic is WIDTH+1 bits to absorb the -2^(W-1) operand.
  - After E{WIDTH} → DONE.
- DIV: restoring divide on magnitudes |op_a|, |op_b|, one quotient bit per edge, E1..E{WIDTH}.
  - Sign fix applied on the transition to DONE.
  - Quotient negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields lo_out=0x80000000, hi_out=0 (wraps, no flag).
- DONE (one cycle, after edge E{WIDTH}):
  - done=1, write_hi=1, write_lo=1.
  - hi_out/lo_out valid.
  - Next edge → IDLE.
- DIVZ (one cycle, after E0):
  - done=1, div_zero=1, write_hi=0, write_lo=0.
  - hi_out/lo_out unchanged.
  - Next edge → IDLE.
- Latency:
  - mult/div: done in cycle WIDTH+1 after the start edge (33 for WIDTH=32).
  - Divide-by-zero: done in cycle 1.
- busy: 1 in MULT/DIV/DONE/DIVZ, 0 in IDLE. A new start is accepted in the cycle after done.
- hi_out/lo_out: hold their last result until the next DONE. They are not cleared by starting a new operation.

Optional Feature:
MULT_DIV_UNSIGNED_EN
- Defined: adds input port op_unsigned (1 bit), sampled with the start.
  - When 1, performs multu/divu.
  - Multiply: operands zero-extended to WIDTH+1 in the Booth datapath.
  - Divide: no magnitude conversion and no sign fix.
- Undefined: port absent; all operations signed.

Decomposition:
- Package mult_div_pkg:
  - state encoding localparams (IDLE, MULT, DIV, DONE, DIVZ);
  - default WIDTH;
  - iteration-counter width, $clog2(WIDTH)+1.
- One combinational sub-module, div_step: a single restoring-divide iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- The Booth step stays inline in mult_div_ctrl.

Test Plan:
- start_mult, op_a=7, op_b=0xFFFFFFFD (-3) → done in cycle 33, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, write_hi=write_lo=1 for exactly that cycle; busy high cycles 1..33.
- start_div, op_a=0xFFFFFFF9 (-7), op_b=2 → lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); op_a=100, op_b=7 → lo_out=14, hi_out=2.
- Divide-by-zero, after a prior mult leaving hi=0x12345678: start_div, op_a=5, op_b=0 → cycle 1: div_zero=1, done=1, no write strobes, hi_out still 0x12345678; busy=0 in cycle 2.
- Corner operands:
  - mult 0x80000000×0x80000000 → hi_out=0x40000000, lo_out=0.
  - div 0x80000000/0xFFFFFFFF → lo_out=0x80000000, hi_out=0.
- Arbitration:
  - start_mult and start_div asserted together (op_b=0) → multiply runs, no div_zero.
  - start_div pulsed at cycle 10 of a mult → ignored; exactly one done.
- Reset asserted asynchronously at cycle 10 of a div → busy, done and outputs 0 immediately; after release, mult 6×7 gives lo_out=42, hi_out=0.
